// File: rtl/unsat_clause_buffer.sv
// Unsat clause buffer: gathers unsatisfied clause indices from the evaluator during a pass
// and hands back a uniformly chosen one per selection request.
module unsat_clause_buffer #(
  parameter int          CLAUSE_W = 12,
  parameter int          IDX_W    = 6,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                eval_valid_i,
  input  logic                eval_unsat_i,
  input  logic [CLAUSE_W-1:0] eval_clause_i,
  input  logic                gather_done_i,
  input  logic                sel_req_i,
  output logic                sel_valid_o,
  output logic [CLAUSE_W-1:0] sel_clause_o,
  output logic [IDX_W:0]      unsat_count_o,
  output logic                all_sat_o,
  output logic                overflow_o,
  output logic                ready_o
);

  localparam int          MAX_UNSAT = 2**IDX_W;
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(MAX_UNSAT);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {IDLE, GATHER, READY, PICK, READ} state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic [IDX_W:0]      count;
  logic [IDX_W-1:0]    sel_idx_p1;
  logic [CLAUSE_W-1:0] mem [MAX_UNSAT];
  logic                store_hit;
  logic                room;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Scales a uniform IDX_W-bit random value into [0, n): floor(r * n / 2**IDX_W).
  function automatic logic [IDX_W-1:0] scale_idx(input logic [IDX_W-1:0] r,
                                                 input logic [IDX_W:0]   n);
    logic [2*IDX_W:0] prod;
    prod = {{(IDX_W+1){1'b0}}, r} * {{IDX_W{1'b0}}, n};
    return prod[2*IDX_W-1:IDX_W];
  endfunction

  assign unsat_count_o = count;
  assign room          = (count < CNT_MAX);
  assign store_hit     = (state == GATHER) && !clear_i && eval_valid_i && eval_unsat_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED_EFF;
    else      lfsr <= lfsr_step(lfsr);
  end

  always_ff @(posedge clk) begin
    if (store_hit && room) mem[count[IDX_W-1:0]] <= eval_clause_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      sel_idx_p1   <= '0;
      sel_valid_o  <= 1'b0;
      sel_clause_o <= '0;
      all_sat_o    <= 1'b0;
      overflow_o   <= 1'b0;
      ready_o      <= 1'b0;
    end else begin
      sel_valid_o <= 1'b0;
      if (clear_i) begin
        state      <= GATHER;
        count      <= '0;
        overflow_o <= 1'b0;
        all_sat_o  <= 1'b0;
        ready_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          GATHER: begin
            if (store_hit) begin
              if (room) count      <= count + 1'b1;
              else      overflow_o <= 1'b1;
            end
            // An evaluation arriving with gather_done still counts toward all_sat.
            if (gather_done_i) begin
              state     <= READY;
              ready_o   <= 1'b1;
              all_sat_o <= (count == '0) && !store_hit;
            end
          end
          READY: begin
            if (sel_req_i && (count != '0)) begin
              state   <= PICK;
              ready_o <= 1'b0;
            end
          end
          // stage p1: random index registered from the free-running LFSR
          PICK: begin
            sel_idx_p1 <= scale_idx(lfsr[IDX_W-1:0], count);
            state      <= READ;
          end
          // stage p2: buffer read, one-cycle valid pulse
          READ: begin
            sel_clause_o <= mem[sel_idx_p1];
            sel_valid_o  <= 1'b1;
            state        <= READY;
            ready_o      <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/unsat_clause_buffer.md
# unsat_clause_buffer

Datapath stage directly downstream of the WalkSAT top-level controller: during the COUNT/GATHER phases it collects the indices of clauses reported unsatisfied by the clause evaluator, keeps a running unsat count, and during the SELECT phase returns one uniformly chosen unsat clause index to the variable-flip logic. It also flags "all clauses satisfied" so the controller can terminate with a solution.

## Interface
- `CLAUSE_W`, 12: width of a clause index.
- `IDX_W`, 6: buffer address width; capacity `MAX_UNSAT = 2**IDX_W` entries.
- `SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clear_i`  in  1  start a new gather pass; empties the buffer.
- `eval_valid_i`  in  1  one evaluated clause result this cycle.
- `eval_unsat_i`  in  1  clause is unsatisfied; qualified by `eval_valid_i`.
- `eval_clause_i`  in  CLAUSE_W  clause index; qualified by `eval_valid_i`.
- `gather_done_i`  in  1  last evaluation of the pass has been presented.
- `sel_req_i`  in  1  request one random unsat clause.
- `sel_valid_o`  out  1  one-cycle pulse; `sel_clause_o` is valid.
- `sel_clause_o`  out  CLAUSE_W  selected clause index, held until the next selection.
- `unsat_count_o`  out  IDX_W+1  number of stored unsat clauses, saturating at MAX_UNSAT.
- `all_sat_o`  out  1  pass complete and count is 0.
- `overflow_o`  out  1  sticky; an unsat clause was dropped this pass.
- `ready_o`  out  1  in READY state; a selection can be accepted.

## Operation
- States: IDLE, GATHER, READY, PICK, READ.
- IDLE: waits for `clear_i`, then goes to GATHER.
- GATHER: each cycle with `eval_valid_i && eval_unsat_i`:
  - if count < MAX_UNSAT, write `eval_clause_i` at address count and increment count;
  - otherwise drop the entry and set `overflow_o`.
  - `gather_done_i` moves the FSM to READY. An evaluation presented in the same cycle as `gather_done_i` is still stored.
- READY:
  - `all_sat_o` = (count == 0).
  - `sel_req_i` with count > 0 moves the FSM to PICK.
  - `sel_req_i` with count == 0 is ignored: no pulse, FSM stays in READY.
- PICK: register idx = (lfsr[IDX_W-1:0] * count) >> IDX_W. This is an IDX_W × (IDX_W+1) product, with full-width intermediate. The result is always < count. Go to READ.
- READ: `sel_clause_o` <= mem[idx], `sel_valid_o` = 1 for one cycle, return to READY. The buffer is not modified, so repeated selections in the same pass are allowed.
- `clear_i` has highest priority in every state. It zeroes the count, clears `overflow_o` and `all_sat_o`, cancels any PICK/READ in flight (no `sel_valid_o` pulse), and goes to GATHER.
- `eval_valid_i` outside GATHER is ignored. `gather_done_i` outside GATHER is ignored.
- LFSR: 16-bit Galois, taps 16'hB400, shifts right every cycle after reset regardless of state.
- Memory: MAX_UNSAT × CLAUSE_W registers, written only in GATHER, not reset.

## Timing
- Reset values:
  - state IDLE;
  - `sel_valid_o`, `sel_clause_o`, `unsat_count_o`, `all_sat_o`, `overflow_o`, `ready_o` all 0;
  - lfsr = SEED.
- Gather write: an input sampled at edge N is reflected in `unsat_count_o` after edge N.
- Readiness: with `gather_done_i` sampled at edge N, `ready_o` and `all_sat_o` are valid after edge N.
- Selection latency: `sel_req_i` sampled at edge N (in READY) gives PICK after N, READ after N+1, and `sel_valid_o` high between edges N+2 and N+3. `ready_o` is low during PICK and READ.
- `sel_req_i` presented during PICK/READ is ignored; the requester waits for `ready_o`.
- Asserting `rst` mid-operation immediately forces all reset values, without waiting for a clock edge.

## Test plan
- Reset:
  - assert `rst` mid-GATHER after 5 writes -> all outputs 0 immediately, state IDLE;
  - after release, `eval_valid_i` pulses without `clear_i` -> count stays 0.
- Gather and count:
  - `clear_i`, then 8 evaluations with unsat on indices 3, 17, 42, 99, and one coinciding with `gather_done_i` (index 7) -> `unsat_count_o`=5, `all_sat_o`=0, `ready_o`=1.
- All satisfied:
  - `clear_i`, 10 satisfied evaluations, `gather_done_i` -> `all_sat_o`=1, count 0;
  - `sel_req_i` -> no `sel_valid_o` within 5 cycles.
- Selection:
  - count=1 with entry 0x05A -> 20 requests each give `sel_clause_o`=0x05A exactly 2 cycles after acceptance;
  - count=5 -> 200 requests return only stored indices, matching a bench LFSR model bit-exactly.
- Overflow (IDX_W=6):
  - 70 unsat evaluations -> count=64, `overflow_o`=1, first 64 indices stored;
  - `clear_i` -> `overflow_o`=0, count=0.
- Clear during selection:
  - `sel_req_i` then `clear_i` one cycle later -> no `sel_valid_o`, state GATHER, count 0.
